// File: rtl/level_pkg.sv
// level_pkg: shared types and helpers for level_ctrl.
//   state_t      - controller states (IDLE, RAMP)
//   sat_step     - one saturating step up or down, clamped to [0, lmax]
//   default_slot - reset contents of preset slot k, min(k, lmax)
// Level math is carried at MAX_W bits here. Callers zero-extend into
// wide_t and truncate the result back to their own level width.
package level_pkg;

  typedef enum logic {IDLE, RAMP} state_t;

  localparam int unsigned MAX_W = 16;
  typedef logic [MAX_W-1:0] wide_t;

  function automatic wide_t sat_step(input wide_t value, input logic inc,
                                     input wide_t lmax);
    wide_t r;
    r = value;
    if (inc) begin
      if (value < lmax) r = value + wide_t'(1);
    end else begin
      if (value != '0) r = value - wide_t'(1);
    end
    return r;
  endfunction

  function automatic wide_t default_slot(input int unsigned k, input wide_t lmax);
    return (k > 32'(lmax)) ? lmax : wide_t'(k);
  endfunction

endpackage

// File: rtl/level_ctrl_btn_edge.sv
// btn_edge: W-wide rising-edge detector with a synchronous active-high reset.
//   clock - system clock
//   reset - clears the previous-value register
//   btn   - synchronised, level-sensitive button inputs
//   rise  - high for one cycle when btn goes 0 -> 1
// The previous-value register clears on reset, so a button that is held
// through reset is reported as a rise on the first cycle after reset.
module btn_edge #(
  parameter int unsigned W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] btn,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev;

  always_ff @(posedge clock) begin
    if (reset) prev <= '0;
    else       prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/level_ctrl.sv
// level_ctrl: multi-channel saturating level controller with preset bank.
//   clock, reset - system clock, synchronous active-high reset
//   up, down     - per-channel step buttons (edge detected)
//   preset_sel   - slot addressed by store/recall
//   store        - save current levels into slot preset_sel
//   recall       - load slot preset_sel (ramped when LEVEL_RAMP_EN)
//   mute         - output mask; stored levels are untouched
//   level        - packed levels, channel c at [c*LEVEL_W +: LEVEL_W]
//   sat          - channel at 0 or full scale
//   busy         - ramp in progress
// Build option: define LEVEL_RAMP_EN to make recall step toward the target
// once every RAMP_DIV cycles; otherwise recall loads in one cycle.
module level_ctrl
  import level_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned LEVEL_W  = 3,
  parameter int unsigned PRESETS  = 4,
  parameter int unsigned RAMP_DIV = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          up,
  input  logic [CHANNELS-1:0]          down,
  input  logic [$clog2(PRESETS)-1:0]   preset_sel,
  input  logic                         store,
  input  logic                         recall,
  input  logic                         mute,
  output logic [CHANNELS*LEVEL_W-1:0]  level,
  output logic [CHANNELS-1:0]          sat,
  output logic                         busy
);

  if (PRESETS < 2) begin : g_chk_presets
    $error("level_ctrl: PRESETS must be at least 2");
  end
  if (RAMP_DIV < 1) begin : g_chk_div
    $error("level_ctrl: RAMP_DIV must be at least 1");
  end
  if (LEVEL_W > MAX_W) begin : g_chk_width
    $error("level_ctrl: LEVEL_W exceeds level_pkg::MAX_W");
  end

  typedef logic [LEVEL_W-1:0] lvl_t;
  localparam lvl_t LMAX = '1;

  lvl_t lvl_q    [CHANNELS];
  lvl_t lvl_d    [CHANNELS];
  lvl_t step_lvl [CHANNELS];
  lvl_t slot_q   [PRESETS][CHANNELS];
  logic slot_we;

  logic [CHANNELS-1:0] up_rise;
  logic [CHANNELS-1:0] down_rise;
  logic [1:0]          cmd_rise;
  logic                store_rise;
  logic                recall_rise;
  logic                sel_ok;
  logic                store_go;
  logic                recall_go;

  btn_edge #(.W(CHANNELS)) u_up_edge (
    .clock(clock), .reset(reset), .btn(up), .rise(up_rise)
  );
  btn_edge #(.W(CHANNELS)) u_down_edge (
    .clock(clock), .reset(reset), .btn(down), .rise(down_rise)
  );
  btn_edge #(.W(2)) u_cmd_edge (
    .clock(clock), .reset(reset), .btn({store, recall}), .rise(cmd_rise)
  );

  assign store_rise  = cmd_rise[1];
  assign recall_rise = cmd_rise[0];
  assign sel_ok      = (32'(preset_sel) < PRESETS);
  assign store_go    = store_rise & sel_ok;
  // Store has priority; a recall in the same cycle is dropped.
  assign recall_go   = recall_rise & ~store_rise & sel_ok;

  // Button stepping; opposing edges on one channel cancel.
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      step_lvl[c] = lvl_q[c];
      if (up_rise[c] != down_rise[c])
        step_lvl[c] = lvl_t'(sat_step(wide_t'(lvl_q[c]), up_rise[c], wide_t'(LMAX)));
    end
  end

`ifdef LEVEL_RAMP_EN
  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  lvl_t             tgt_q    [CHANNELS];
  lvl_t             tgt_d    [CHANNELS];
  lvl_t             ramp_lvl [CHANNELS];
  logic             at_tgt;
  logic             step_done;

  // One step toward the target on every channel. step_done lets the FSM
  // leave RAMP on the same edge as the final step, so busy lasts exactly
  // D*RAMP_DIV cycles.
  always_comb begin
    at_tgt    = 1'b1;
    step_done = 1'b1;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      ramp_lvl[c] = lvl_q[c];
      if (lvl_q[c] != tgt_q[c]) begin
        at_tgt      = 1'b0;
        ramp_lvl[c] = lvl_t'(sat_step(wide_t'(lvl_q[c]), lvl_q[c] < tgt_q[c],
                                      wide_t'(LMAX)));
      end
      if (ramp_lvl[c] != tgt_q[c]) step_done = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    slot_we = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      lvl_d[c] = lvl_q[c];
      tgt_d[c] = tgt_q[c];
    end
    case (state_q)
      IDLE: begin
        if (recall_go) begin
          for (int unsigned c = 0; c < CHANNELS; c++) tgt_d[c] = slot_q[preset_sel][c];
          div_d   = '0;
          state_d = RAMP;
        end else begin
          slot_we = store_go;
          for (int unsigned c = 0; c < CHANNELS; c++) lvl_d[c] = step_lvl[c];
        end
      end
      RAMP: begin
        if (recall_rise && sel_ok) begin
          for (int unsigned c = 0; c < CHANNELS; c++) tgt_d[c] = slot_q[preset_sel][c];
          div_d = '0;
        end else if (at_tgt) begin
          state_d = IDLE;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          for (int unsigned c = 0; c < CHANNELS; c++) lvl_d[c] = ramp_lvl[c];
          if (step_done) state_d = IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) tgt_q[c] <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      for (int unsigned c = 0; c < CHANNELS; c++) tgt_q[c] <= tgt_d[c];
    end
  end

  assign busy = (state_q == RAMP);
`else
  always_comb begin
    slot_we = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) lvl_d[c] = lvl_q[c];
    if (recall_go) begin
      for (int unsigned c = 0; c < CHANNELS; c++) lvl_d[c] = slot_q[preset_sel][c];
    end else begin
      slot_we = store_go;
      for (int unsigned c = 0; c < CHANNELS; c++) lvl_d[c] = step_lvl[c];
    end
  end

  assign busy = 1'b0;
`endif

  // The slot captures the pre-step levels of the store cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned c = 0; c < CHANNELS; c++) lvl_q[c] <= '0;
      for (int unsigned k = 0; k < PRESETS; k++)
        for (int unsigned c = 0; c < CHANNELS; c++)
          slot_q[k][c] <= lvl_t'(default_slot(k, wide_t'(LMAX)));
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) lvl_q[c] <= lvl_d[c];
      if (slot_we)
        for (int unsigned c = 0; c < CHANNELS; c++) slot_q[preset_sel][c] <= lvl_q[c];
    end
  end

  always_comb begin
    level = '0;
    sat   = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      level[c*LEVEL_W +: LEVEL_W] = mute ? '0 : lvl_q[c];
      sat[c] = (lvl_q[c] == '0) || (lvl_q[c] == LMAX);
    end
  end

endmodule

// File: tb/tb_level_ctrl.sv
// tb_level_ctrl: self-checking bench for level_ctrl (default parameters).
// Adapts its recall expectations to LEVEL_RAMP_EN when that macro is set.
module tb_level_ctrl;

  localparam int CH   = 2;
  localparam int LW   = 3;
  localparam int NP   = 4;
  localparam int RD   = 4;
  localparam int LMAX = 7;

  logic            clock;
  logic            reset;
  logic [CH-1:0]   up, down;
  logic [1:0]      preset_sel;
  logic            store, recall, mute;
  logic [CH*LW-1:0] level;
  logic [CH-1:0]   sat;
  logic            busy;

  level_ctrl #(.CHANNELS(CH), .LEVEL_W(LW), .PRESETS(NP), .RAMP_DIV(RD)) dut (
    .clock(clock), .reset(reset), .up(up), .down(down),
    .preset_sel(preset_sel), .store(store), .recall(recall), .mute(mute),
    .level(level), .sat(sat), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer levels, slot array, per-button previous values.
  int m_lvl  [CH];
  int m_slot [NP][CH];
  int m_tgt  [CH];
  bit m_ramp;
  int m_age;
  bit p_up [CH];
  bit p_dn [CH];
  bit p_st, p_rc;

  task automatic model_edge();
    bit ue [CH];
    bit de [CH];
    bit se, re, eq;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_lvl[c] = 0; m_tgt[c] = 0; p_up[c] = 0; p_dn[c] = 0;
      end
      for (int k = 0; k < NP; k++)
        for (int c = 0; c < CH; c++) m_slot[k][c] = (k < LMAX) ? k : LMAX;
      p_st = 0; p_rc = 0; m_ramp = 0; m_age = 0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        ue[c] = up[c] && !p_up[c];
        de[c] = down[c] && !p_dn[c];
        p_up[c] = up[c];
        p_dn[c] = down[c];
      end
      se = store && !p_st;
      re = recall && !p_rc;
      p_st = store;
      p_rc = recall;
      if (!m_ramp) begin
        if (se)
          for (int c = 0; c < CH; c++) m_slot[preset_sel][c] = m_lvl[c];
        if (re && !se) begin
`ifdef LEVEL_RAMP_EN
          for (int c = 0; c < CH; c++) m_tgt[c] = m_slot[preset_sel][c];
          m_ramp = 1;
          m_age  = 0;
`else
          for (int c = 0; c < CH; c++) m_lvl[c] = m_slot[preset_sel][c];
`endif
        end else begin
          for (int c = 0; c < CH; c++) begin
            if (ue[c] && !de[c] && m_lvl[c] < LMAX) m_lvl[c]++;
            if (de[c] && !ue[c] && m_lvl[c] > 0)    m_lvl[c]--;
          end
        end
      end else begin
        if (re) begin
          for (int c = 0; c < CH; c++) m_tgt[c] = m_slot[preset_sel][c];
          m_age = 0;
        end else begin
          m_age++;
          if (m_age % RD == 0)
            for (int c = 0; c < CH; c++) begin
              if (m_tgt[c] > m_lvl[c]) m_lvl[c]++;
              else if (m_tgt[c] < m_lvl[c]) m_lvl[c]--;
            end
          eq = 1;
          for (int c = 0; c < CH; c++) if (m_lvl[c] != m_tgt[c]) eq = 0;
          if (eq) m_ramp = 0;
        end
      end
    end
  endtask

  task automatic model_check(input string name);
    logic [CH*LW-1:0] el;
    logic [CH-1:0]    es;
    for (int c = 0; c < CH; c++) begin
      el[c*LW +: LW] = mute ? '0 : LW'(m_lvl[c]);
      es[c] = (m_lvl[c] == 0) || (m_lvl[c] == LMAX);
    end
    check({name, "_level"}, 32'(level), 32'(el));
    check({name, "_sat"},   32'(sat),   32'(es));
    check({name, "_busy"},  32'(busy),  32'(m_ramp));
  endtask

  function automatic logic [CH*LW-1:0] pack(input int l0, input int l1);
    return {LW'(l1), LW'(l0)};
  endfunction

  task automatic cycle(input logic [1:0] u, input logic [1:0] d, input logic [1:0] s,
                       input logic st, input logic rc, input logic mu, input logic rs);
    @(negedge clock);
    up = u; down = d; preset_sel = s; store = st; recall = rc; mute = mu; reset = rs;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    cycle(2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Cycle plus explicit expected levels, cross-checked with the model.
  task automatic step_chk(input string name, input logic [1:0] u, input logic [1:0] d,
                          input logic [1:0] s, input logic st, input logic rc,
                          input int l0, input int l1);
    cycle(u, d, s, st, rc, 1'b0, 1'b0);
    check(name, 32'(level), 32'(pack(l0, l1)));
    model_check(name);
  endtask

  typedef struct {
    logic [1:0] u;
    logic [1:0] d;
    logic [1:0] sel;
    logic       st;
    logic       rc;
    logic       mu;
    int         l0;
    int         l1;
  } vec_t;

  vec_t tbl[$];

  task automatic push(input logic [1:0] u, input logic [1:0] d, input logic [1:0] s,
                      input logic st, input logic mu, input int l0, input int l1);
    vec_t v;
    v.u = u; v.d = d; v.sel = s; v.st = st; v.rc = 1'b0; v.mu = mu; v.l0 = l0; v.l1 = l1;
    tbl.push_back(v);
  endtask

  int busy_cnt;
  int e;

  initial begin
    reset = 1'b1; up = '0; down = '0; preset_sel = '0;
    store = 1'b0; recall = 1'b0; mute = 1'b0;

    // Nine pulses on channel 0 saturate at 7; channel 1 stays 0.
    for (int i = 1; i <= 9; i++) begin
      push(2'b01, 2'b00, 2'd0, 1'b0, 1'b0, (i < LMAX) ? i : LMAX, 0);
      push(2'b00, 2'b00, 2'd0, 1'b0, 1'b0, (i < LMAX) ? i : LMAX, 0);
    end
    // Holding up[1] steps once.
    for (int i = 0; i < 10; i++) push(2'b10, 2'b00, 2'd0, 1'b0, 1'b0, 7, 1);
    push(2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 7, 1);
    push(2'b10, 2'b00, 2'd0, 1'b0, 1'b0, 7, 2);
    push(2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 7, 2);
    push(2'b10, 2'b00, 2'd0, 1'b0, 1'b0, 7, 3);
    push(2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 7, 3);
    // Up and down together cancel.
    push(2'b10, 2'b10, 2'd0, 1'b0, 1'b0, 7, 3);
    push(2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 7, 3);
    // Reach {5,2}, store to slot 2, then step both down.
    push(2'b00, 2'b11, 2'd0, 1'b0, 1'b0, 6, 2);
    push(2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 6, 2);
    push(2'b00, 2'b01, 2'd0, 1'b0, 1'b0, 5, 2);
    push(2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 5, 2);
    push(2'b00, 2'b00, 2'd2, 1'b1, 1'b0, 5, 2);
    push(2'b00, 2'b00, 2'd2, 1'b0, 1'b0, 5, 2);
    push(2'b00, 2'b11, 2'd0, 1'b0, 1'b0, 4, 1);
    push(2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 4, 1);
    // Mute masks output only; stepping continues underneath.
    push(2'b00, 2'b00, 2'd0, 1'b0, 1'b1, 4, 1);
    push(2'b01, 2'b00, 2'd0, 1'b0, 1'b1, 5, 1);
    push(2'b00, 2'b00, 2'd0, 1'b0, 1'b1, 5, 1);
    push(2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 5, 1);

    do_reset();
    check("reset_level", 32'(level), 32'(0));
    check("reset_sat",   32'(sat),   32'(2'b11));
    check("reset_busy",  32'(busy),  32'(0));

    foreach (tbl[i]) begin
      cycle(tbl[i].u, tbl[i].d, tbl[i].sel, tbl[i].st, tbl[i].rc, tbl[i].mu, 1'b0);
      check("tbl_level", 32'(level), tbl[i].mu ? 32'(0) : 32'(pack(tbl[i].l0, tbl[i].l1)));
      check("tbl_sat", 32'(sat),
            32'({(tbl[i].l1 == 0 || tbl[i].l1 == LMAX), (tbl[i].l0 == 0 || tbl[i].l0 == LMAX)}));
      check("tbl_busy", 32'(busy), 32'(0));
    end

`ifndef LEVEL_RAMP_EN
    // Direct recall of slot 2; up edges in the recall cycle are dropped.
    step_chk("pre_recall",  2'b00, 2'b01, 2'd0, 1'b0, 1'b0, 4, 1);
    step_chk("pre_recall2", 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 4, 1);
    step_chk("recall2",     2'b11, 2'b00, 2'd2, 1'b0, 1'b1, 5, 2);
    step_chk("recall2_rel", 2'b00, 2'b00, 2'd2, 1'b0, 1'b0, 5, 2);
    // Store and recall together: store wins, levels unchanged.
    step_chk("up1",         2'b10, 2'b00, 2'd0, 1'b0, 1'b0, 5, 3);
    step_chk("up1_rel",     2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 5, 3);
    step_chk("store_rc",    2'b00, 2'b00, 2'd1, 1'b1, 1'b1, 5, 3);
    step_chk("store_rc_rel",2'b00, 2'b00, 2'd1, 1'b0, 1'b0, 5, 3);
    step_chk("dn0",         2'b00, 2'b01, 2'd0, 1'b0, 1'b0, 4, 3);
    step_chk("dn0_rel",     2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 4, 3);
    step_chk("recall1",     2'b00, 2'b00, 2'd1, 1'b0, 1'b1, 5, 3);
    step_chk("recall1_rel", 2'b00, 2'b00, 2'd1, 1'b0, 1'b0, 5, 3);
`else
    // Ramp from {0,0} to slot 3 {3,3}: a step every RD cycles, busy 3*RD cycles.
    do_reset();
    busy_cnt = 0;
    for (int t = 0; t <= 13; t++) begin
      cycle((t == 5) ? 2'b11 : 2'b00, 2'b00, 2'd3, 1'b0, (t == 0), 1'b0, 1'b0);
      e = (t / RD > 3) ? 3 : t / RD;
      check("ramp_level", 32'(level), 32'(pack(e, e)));
      check("ramp_busy",  32'(busy),  32'(t < 3 * RD));
      model_check("ramp");
      busy_cnt += int'(busy);
    end
    check("ramp_busy_len", 32'(busy_cnt), 32'(3 * RD));

    // Redirect mid-ramp to slot 1 {1,1}: levels turn around.
    do_reset();
    for (int t = 0; t <= 14; t++) begin
      cycle(2'b00, 2'b00, (t >= 9) ? 2'd1 : 2'd3, 1'b0, (t == 0) || (t == 9), 1'b0, 1'b0);
      e = (t < 4) ? 0 : (t < 8) ? 1 : (t < 13) ? 2 : 1;
      check("redir_level", 32'(level), 32'(pack(e, e)));
      check("redir_busy",  32'(busy),  32'(t < 13));
      model_check("redir");
    end

    // Reset aborts a ramp immediately.
    do_reset();
    cycle(2'b00, 2'b00, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 5; t++) cycle(2'b00, 2'b00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_pre_busy", 32'(busy), 32'(1));
    cycle(2'b00, 2'b00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    check("abort_level", 32'(level), 32'(0));
    check("abort_busy",  32'(busy),  32'(0));
    check("abort_sat",   32'(sat),   32'(2'b11));
`endif

    // A button held through reset registers on the first cycle afterwards.
    cycle(2'b01, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(2'b01, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step_chk("held_rst",  2'b01, 2'b00, 2'd0, 1'b0, 1'b0, 1, 0);
    step_chk("held_rst2", 2'b01, 2'b00, 2'd0, 1'b0, 1'b0, 1, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle({1'($urandom % 3 == 0), 1'($urandom % 3 == 0)},
            {1'($urandom % 3 == 0), 1'($urandom % 3 == 0)},
            2'($urandom_range(0, NP - 1)),
            1'($urandom % 6 == 0),
            1'($urandom % 8 == 0),
            1'($urandom % 5 == 0),
            1'($urandom % 97 == 0));
      model_check("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
